// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier sharing arbiter.
// Holds operand widths, the result tag and the round-robin pick.
package mult_share_arbiter_pkg;

    localparam int MUL_W    = 8;
    localparam int PROD_W   = 16;
    localparam int NREQ_MAX = 8;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [ID_MAX_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    // Scans from the far end so the nearest offset is written last.
    function automatic pick_t rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input logic [ID_MAX_W-1:0] ptr,
        input int                  n
    );
        pick_t p;
        int    j;
        p = '0;
        for (int i = NREQ_MAX - 1; i >= 0; i--) begin
            if (i < n) begin
                j = (int'(ptr) + i) % n;
                if (req[j]) begin
                    p.found = 1'b1;
                    p.idx   = ID_MAX_W'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick, registered pointer.
// The pointer moves to one past the last winner.
module rr_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            cclk,
    input  logic            rstb,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    logic [IDW-1:0] rr_ptr;
    pick_t          pick;

    // Winner selection; nothing is granted while reset is held.
    always_comb begin
        pick    = rr_pick(NREQ_MAX'(req), ID_MAX_W'(rr_ptr), NREQ);
        gnt_any = pick.found & rstb;
        gnt_id  = IDW'(pick.idx);
        gnt     = gnt_any ? (NREQ'(1) << gnt_id) : '0;
    end

    // Pointer advances past the winner, wrapping at NREQ.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            if (int'(gnt_id) == NREQ - 1)
                rr_ptr <= '0;
            else
                rr_ptr <= gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_8bit.sv
// Registered 8x8 unsigned multiplier, one cycle from X/Y to Z.
// Shared by several requesters through mult_share_arbiter.
module multiplier_8bit (
    input  logic        clk,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [15:0] Z
);

    // Product registered on every edge.
    always_ff @(posedge clk) begin
        Z <= X * Y;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier_8bit among NREQ requesters, one grant per cycle.
// Results return in grant order, MUL_LAT+1 cycles after the grant.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 2
) (
    input  logic                  cclk,
    input  logic                  rstb,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*MUL_W-1:0] x_in,
    input  logic [NREQ*MUL_W-1:0] y_in,
    output logic [NREQ-1:0]       gnt,
    output logic [PROD_W-1:0]     z_out,
    output logic [NREQ-1:0]       z_valid,
    output logic                  busy
);

    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;
    logic [MUL_W-1:0]  x_r;
    logic [MUL_W-1:0]  y_r;
    logic [PROD_W-1:0] z_mul;
    logic [PROD_W-1:0] z_hold;
    tag_t              tag_q [MUL_LAT+1];
    tag_t              tag_last;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .cclk    (cclk),
        .rstb    (rstb),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    multiplier_8bit u_mul (
        .clk (cclk),
        .X   (x_r),
        .Y   (y_r),
        .Z   (z_mul)
    );

    // Capture the winner's operands; hold them when idle.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            x_r <= '0;
            y_r <= '0;
        end else if (gnt_any) begin
            x_r <= x_in[int'(gnt_id)*MUL_W +: MUL_W];
            y_r <= y_in[int'(gnt_id)*MUL_W +: MUL_W];
        end
    end

    // Tag pipeline tracks the owner alongside the multiplier, no stall.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            for (int i = 0; i <= MUL_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{gnt_any, ID_MAX_W'(gnt_id)};
            for (int i = 1; i <= MUL_LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    // Last delivered product, shown on z_out between results.
    always_ff @(posedge cclk) begin
        if (!rstb)
            z_hold <= '0;
        else if (tag_last.valid)
            z_hold <= z_mul;
    end

    // Result steering and in-flight flag, forced quiet under reset.
    always_comb begin
        tag_last = tag_q[MUL_LAT];
        busy     = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++)
            busy = busy | tag_q[i].valid;
        busy = busy & rstb;
        if (rstb && tag_last.valid) begin
            z_valid = NREQ'(1) << tag_last.id;
            z_out   = z_mul;
        end else begin
            z_valid = '0;
            z_out   = rstb ? z_hold : '0;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a queue-based model.
// Directed scenarios followed by a randomized request phase.
module tb_mult_share_arbiter;

    localparam int N = 4;

    logic          cclk = 1'b0;
    logic          rstb = 1'b0;
    logic [N-1:0]  req  = '0;
    logic [N*8-1:0] x_in = '0;
    logic [N*8-1:0] y_in = '0;
    logic [N-1:0]  gnt;
    logic [15:0]   z_out;
    logic [N-1:0]  z_valid;
    logic          busy;

    mult_share_arbiter #(
        .NREQ    (N),
        .MUL_LAT (1),
        .IDW     (2)
    ) dut (
        .cclk    (cclk),
        .rstb    (rstb),
        .req     (req),
        .x_in    (x_in),
        .y_in    (y_in),
        .gnt     (gnt),
        .z_out   (z_out),
        .z_valid (z_valid),
        .busy    (busy)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        int due;
        int id;
        int prod;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    int   xa [N];
    int   ya [N];
    int   waitc [N];
    int   ptr_m   = 0;
    int   cyc     = 0;
    int   zhold_m = 0;
    int   exp_k   = -1;
    res_t q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [N-1:0] r);
        req = r;
        for (int i = 0; i < N; i++) begin
            x_in[8*i +: 8] = 8'(xa[i]);
            y_in[8*i +: 8] = 8'(ya[i]);
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        int           ez;
        logic         eb;
        @(negedge cclk);
        exp_k = -1;
        if (rstb)
            for (int o = N - 1; o >= 0; o--)
                if (req[(ptr_m + o) % N])
                    exp_k = (ptr_m + o) % N;
        eg = (exp_k >= 0) ? N'(1 << exp_k) : '0;
        ev = '0;
        ez = rstb ? zhold_m : 0;
        eb = rstb && (q.size() > 0);
        if (rstb && q.size() > 0 && q[0].due == cyc) begin
            ev      = N'(1 << q[0].id);
            ez      = q[0].prod;
            zhold_m = q[0].prod;
            void'(q.pop_front());
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("z_valid", 32'(z_valid), 32'(ev));
        chk("z_out", 32'(z_out), 32'(ez));
        chk("busy", 32'(busy), 32'(eb));
        for (int i = 0; i < N; i++) begin
            if (gnt[i])
                chk("fair_wait", 32'(waitc[i] < N), 32'd1);
            if (rstb && req[i] && !gnt[i])
                waitc[i]++;
            else
                waitc[i] = 0;
        end
        @(posedge cclk);
        if (!rstb) begin
            ptr_m   = 0;
            zhold_m = 0;
            q.delete();
        end else if (exp_k >= 0) begin
            q.push_back('{cyc + 2, exp_k, xa[exp_k] * ya[exp_k]});
            ptr_m = (exp_k + 1) % N;
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            xa[i]    = 0;
            ya[i]    = 0;
            waitc[i] = 0;
        end
        rstb = 1'b0;
        drive('0);
        repeat (3) tick();
        rstb = 1'b1;

        xa[0] = 12;
        ya[0] = 10;
        drive(4'b0001);
        tick();
        drive('0);
        repeat (3) tick();

        rstb = 1'b0;
        for (int i = 0; i < N; i++) begin
            xa[i] = $urandom_range(0, 255);
            ya[i] = $urandom_range(0, 255);
        end
        drive(4'b1111);
        repeat (2) tick();
        rstb = 1'b1;
        repeat (10) begin
            tick();
            if (exp_k >= 0) begin
                xa[exp_k] = $urandom_range(0, 255);
                ya[exp_k] = $urandom_range(0, 255);
            end
            drive(4'b1111);
        end
        drive('0);
        repeat (3) tick();

        drive(4'b0100);
        tick();
        drive(4'b1010);
        tick();
        drive(4'b0010);
        tick();
        drive('0);
        repeat (3) tick();

        xa[0] = 255;
        ya[0] = 255;
        drive(4'b0001);
        tick();
        xa[0] = 0;
        ya[0] = 200;
        drive(4'b0001);
        tick();
        drive('0);
        repeat (3) tick();

        xa[1] = 7;
        ya[1] = 9;
        drive(4'b0010);
        tick();
        rstb = 1'b0;
        drive('0);
        tick();
        rstb = 1'b1;
        drive(4'b1100);
        tick();
        drive('0);
        repeat (3) tick();

        ya[2] = 10;
        for (int v = 10; v <= 30; v += 10) begin
            xa[2] = v;
            drive(4'b0100);
            tick();
        end
        drive('0);
        repeat (3) tick();

        r = '0;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!r[i] || exp_k == i) begin
                    r[i]  = ($urandom_range(0, 2) != 0);
                    xa[i] = $urandom_range(0, 255);
                    ya[i] = $urandom_range(0, 255);
                end
            end
            rstb = ($urandom_range(0, 49) != 0);
            drive(r);
            tick();
        end
        rstb = 1'b1;
        drive('0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one instance of the existing registered 8x8 unsigned multiplier, multiplier_8bit, among NREQ requesters.
- Typical requesters are the encoder_to_rpm gear-ratio paths of several motor channels plus PWM duty scaling.
- Grants one operand pair per cycle using round-robin arbitration.
- Returns each 16-bit product to its owner with a one-hot valid, at a fixed latency.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- MUL_LAT, 1: cycles from multiplier X/Y input change to a valid Z. Must match multiplier_8bit.
- IDW, 2: requester-index width, clog2(NREQ).

Ports:
- cclk  input  1  system clock
- rstb  input  1  reset
- req  input  NREQ  per-requester request; held high with stable operands until gnt is seen
- x_in  input  NREQ*8  operand X, requester i at bits [8i+7:8i]
- y_in  input  NREQ*8  operand Y, same packing
- gnt  output  NREQ  one-hot, combinational; high in the cycle operands are captured
- z_out  output  16  product, meaningful only while z_valid is nonzero
- z_valid  output  NREQ  one-hot, one-cycle pulse marking the owner of z_out
- busy  output  1  high while any product is in flight

Behaviour:
- Reset: rstb, synchronous, active-low; clock cclk. All state updates on posedge cclk.
- Values while rstb is low: gnt=0, z_valid=0, z_out=0, busy=0, rr_ptr=0, operand registers=0, tag pipeline cleared.
- Arbitration (combinational each cycle):
  - Scan req starting at index rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - gnt = one-hot of the winner; gnt=0 when req=0.
  - At most one grant per cycle.
- Pointer update: on a grant to index k, rr_ptr <= (k+1) mod NREQ. No grant leaves rr_ptr unchanged.
- Fairness: a continuously asserted req is granted within NREQ cycles.
- Capture: on the edge ending a grant cycle t:
  - X_r <= x_in[k], Y_r <= y_in[k];
  - tag stage 0 <= {valid=1, id=k}.
  - With no grant, tag stage 0 valid <= 0 and X_r/Y_r hold.
- Tag pipeline: depth 1+MUL_LAT, shifting every cycle with no stall.
- Result timing: z_valid[id] and z_out = multiplier Z appear in cycle t+1+MUL_LAT.
  - Default case: grant in cycle t gives the result in cycle t+2.
  - z_out is registered from Z. Outside valid cycles it holds its last value.
- Back-to-back: a requester holding req across consecutive cycles is granted again only if it is the sole requester. Each grant consumes the operands present in that cycle.
- Requester protocol: deassert req, or present new operands, in the cycle after gnt.
- Result order: always equals grant order. No reordering, no backpressure; requesters must accept z_valid unconditionally.
- Arithmetic: unsigned 8x8 -> 16 with no truncation. 255*255 = 0xFE01. Signed (wrapped) rev counts are the requester's concern.
- busy = OR of all tag valid bits.
- Reset mid-operation: every in-flight tag is dropped. No z_valid is issued for grants made before reset. Arbitration restarts at index 0.
- A req that is high during reset is granted in the first cycle after rstb goes high.

Decomposition:
- Shared package holds:
  - MUL_W=8, PROD_W=16;
  - tag struct {valid, id[IDW-1:0]};
  - function for the round-robin priority pick.
- One sub-module: rr_arbiter (NREQ-wide, combinational pick plus registered rr_ptr).
- multiplier_8bit is instantiated directly, unchanged.

Test Plan:
- Single requester: req[0]=1, x=12, y=10 in cycle t → gnt[0]=1 in t; z_valid=0001 and z_out=120 in t+2; busy high t+1..t+2.
- Full load: all four req held high from reset release → gnt sequence 0,1,2,3,0,1… once per cycle; z_valid follows the same sequence two cycles later.
- Pointer priority: after last grant to 2, req[1] and req[3] rise together → gnt[3] first, gnt[1] next cycle.
- Extremes: x=255, y=255 → z_out=0xFE01. Then x=0, y=200 → z_out=0.
- Reset mid-flight: grant in cycle t, rstb=0 in t+1 → no z_valid in t+2; all outputs 0; the next grant after release goes to the lowest requesting index.
- Sole streaming requester: req[2] held 3 cycles with x=10/20/30, y=10 → three consecutive gnt[2]; z_out 100, 200, 300 on consecutive cycles.
